tl_phase_timer: RTL
===================

// Module: tl_phase_timer
// PURPOSE
//  Phase-duration timer for the left-turn traffic-light controller. It sits directly
//  downstream of the 3-bit state register and consumes its q output. It times how long
//  the current light phase has been active, then returns a one-cycle expire pulse.
//  The next-state logic uses that pulse to advance the FSM.
// PARAMETERS
//  CNT_W       4   width of the phase down-counter; every *_CYC must be < 2**CNT_W
//  GREEN_CYC   8   ticks spent in a straight-green phase (states 000, 100)
//  LEFT_CYC    4   ticks spent in a left-arrow phase (states 010, 110)
//  YELLOW_CYC  2   ticks spent in any yellow phase (states 001, 011, 101, 111)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous active-low reset
//  state      in   3      current FSM state, taken from the state register q
//  tick       in   1      one-cycle timebase strobe; counting advances only on tick
//  hold       in   1      freezes the counter (maintenance/pedestrian override)
//  expire     out  1      one-cycle pulse: the current phase has elapsed
//  remaining  out  CNT_W  ticks left in the phase (cnt value)
// BEHAVIOUR
//  Phase encoding:
//   000 A-green, 001 A-yellow, 010 A-left, 011 A-left-yellow
//   100 B-green, 101 B-yellow, 110 B-left, 111 B-left-yellow
//  Duration function dur(s):
//   s[0]=1 gives YELLOW_CYC
//   s[1:0]=10 gives LEFT_CYC
//   otherwise GREEN_CYC
//  Registers: prev_state[2:0], cnt[CNT_W-1:0], expire (registered).
//  Reset (async, reset_n=0):
//   prev_state=000, cnt=GREEN_CYC-1, expire=0, remaining=GREEN_CYC-1
//  Each rising clk, in priority order:
//   1. state != prev_state: prev_state<=state; cnt<=dur(state)-1; expire<=0.
//      Reload beats tick and hold.
//   2. hold=1: cnt holds; expire<=0.
//   3. tick=1 and cnt!=0: cnt<=cnt-1; expire<=0.
//   4. tick=1 and cnt==0: expire<=1; cnt holds at 0 until the state changes.
//   5. otherwise: cnt holds; expire<=0.
//  Latency:
//   - expire rises one clk after the tick that finds cnt==0.
//   - A phase of N cycles therefore produces expire after the N-th tick.
//  expire is never high two cycles in a row, so it cannot double-advance the FSM.
//  If next-state logic ignores expire (state unchanged), a fresh pulse fires on every
//  later tick while cnt==0.
//  Reset mid-phase: async clear to the reset values above. The state register resets
//  to 000 in the same event, so no spurious reload occurs.
//  remaining = cnt, combinational from the register, with no added latency.
//  Parameter legality: every *_CYC >= 1. Elaboration errors (generate-time check) if
//  any *_CYC is 0 or >= 2**CNT_W.
// STRUCTURE
//  Shared include tl_defs.vh holds:
//   - the 3-bit phase encoding localparams (S_AG .. S_BLY)
//   - the default cycle counts, so FSM, output decoder and timer agree
//  Natural sub-module: _dcnt_ld_r. It is a CNT_W-bit down-counter with async
//  active-low reset, synchronous load (ld, ld_val), enable, and a zero flag.
//  The top level holds the dur() mux, the change comparator, prev_state and expire.
// TESTING
//  1. Reset with state=000, then 8 ticks
//     -> remaining 7,6..0; expire pulses once, 1 clk after the 8th tick.
//  2. At remaining=3, change state 000->001 with tick=1 in the same cycle
//     -> reload wins; remaining=1 next clk; expire after 2 more ticks.
//  3. state=010 with hold=1 for 5 ticks
//     -> remaining stays 3, no expire; release hold -> expire after 4 ticks total.
//  4. Leave state=101 past expiry
//     -> expire pulses on every later tick, each only 1 clk wide.
//  5. Assert reset_n=0 asynchronously mid-clock at remaining=5 in state 100
//     -> immediate remaining=7, expire=0, prev_state=000.
//  6. Walk all 8 states, driving the FSM from expire
//     -> phase lengths 8,2,4,2,8,2,4,2 ticks.

Source files
------------

// File: rtl/tl_phase_timer_pkg.sv
// Shared definitions for the left-turn traffic-light controller: phase
// encoding, default phase lengths and phase classification helpers.
package tl_phase_timer_pkg;

  // 3-bit phase encoding driven by the controller state register
  typedef enum logic [2:0] {
    S_AG  = 3'b000,  // A straight green
    S_AY  = 3'b001,  // A yellow
    S_AL  = 3'b010,  // A left arrow
    S_ALY = 3'b011,  // A left yellow
    S_BG  = 3'b100,  // B straight green
    S_BY  = 3'b101,  // B yellow
    S_BL  = 3'b110,  // B left arrow
    S_BLY = 3'b111   // B left yellow
  } tl_phase_e;

  // Default phase lengths in timebase ticks; FSM, decoder and timer share these
  localparam int unsigned TL_CNT_W      = 4;
  localparam int unsigned TL_GREEN_CYC  = 8;
  localparam int unsigned TL_LEFT_CYC   = 4;
  localparam int unsigned TL_YELLOW_CYC = 2;

  // Every yellow phase has bit 0 set
  function automatic logic phase_is_yellow(input tl_phase_e s);
    logic [2:0] v;
    v = s;
    return v[0];
  endfunction

  // Left-arrow phases are x10
  function automatic logic phase_is_left(input tl_phase_e s);
    logic [2:0] v;
    v = s;
    return (v[1:0] == 2'b10);
  endfunction

endpackage

// File: rtl/tl_phase_timer_dcnt_ld_r.sv
// Down-counter with async active-low reset, synchronous load, enable and a
// zero flag. The count never wraps below zero.
module tl_phase_timer_dcnt_ld_r #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority over decrement; decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tl_phase_timer.sv
// Phase-duration timer for the left-turn traffic-light controller. Watches
// the controller state, reloads a down-counter with the phase length on every
// state change, counts timebase ticks and returns a one-cycle expire pulse.
module tl_phase_timer
  import tl_phase_timer_pkg::*;
#(
  parameter int unsigned CNT_W      = TL_CNT_W,
  parameter int unsigned GREEN_CYC  = TL_GREEN_CYC,
  parameter int unsigned LEFT_CYC   = TL_LEFT_CYC,
  parameter int unsigned YELLOW_CYC = TL_YELLOW_CYC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       state,
  input  logic             tick,
  input  logic             hold,
  output logic             expire,
  output logic [CNT_W-1:0] remaining
);

  localparam longint unsigned CYC_LIMIT = longint'(1) << CNT_W;

  // Reject phase lengths of zero or too large for the counter
  if (GREEN_CYC == 0 || longint'(GREEN_CYC) >= CYC_LIMIT) begin : g_bad_green
    $error("tl_phase_timer: GREEN_CYC must be in 1 .. 2**CNT_W-1");
  end
  if (LEFT_CYC == 0 || longint'(LEFT_CYC) >= CYC_LIMIT) begin : g_bad_left
    $error("tl_phase_timer: LEFT_CYC must be in 1 .. 2**CNT_W-1");
  end
  if (YELLOW_CYC == 0 || longint'(YELLOW_CYC) >= CYC_LIMIT) begin : g_bad_yellow
    $error("tl_phase_timer: YELLOW_CYC must be in 1 .. 2**CNT_W-1");
  end

  tl_phase_e        phase;
  tl_phase_e        prev_state_q;
  tl_phase_e        prev_state_d;
  logic             expire_q;
  logic             expire_d;
  logic [CNT_W-1:0] reload_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_ld;
  logic             cnt_en;
  logic             phase_chg;

  assign phase     = tl_phase_e'(state);
  assign phase_chg = (phase != prev_state_q);

  // Reload value dur(state)-1 for the phase being entered
  always_comb begin
    reload_val = CNT_W'(GREEN_CYC - 1);
    if (phase_is_yellow(phase)) begin
      reload_val = CNT_W'(YELLOW_CYC - 1);
    end else if (phase_is_left(phase)) begin
      reload_val = CNT_W'(LEFT_CYC - 1);
    end
  end

  // Priority: phase change reload, then hold, then tick decrement / expiry
  always_comb begin
    prev_state_d = prev_state_q;
    cnt_ld       = 1'b0;
    cnt_en       = 1'b0;
    expire_d     = 1'b0;
    if (phase_chg) begin
      prev_state_d = phase;
      cnt_ld       = 1'b1;
    end else if (hold) begin
      // counter frozen, no pulse
    end else if (tick) begin
      if (!cnt_zero) begin
        cnt_en = 1'b1;
      end else begin
        expire_d = 1'b1;
      end
    end
  end

  // Phase tracking and registered expire pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state_q <= S_AG;
      expire_q     <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      expire_q     <= expire_d;
    end
  end

  tl_phase_timer_dcnt_ld_r #(
    .CNT_W   (CNT_W),
    .RST_VAL (GREEN_CYC - 1)
  ) u_dcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (cnt_ld),
    .ld_val  (reload_val),
    .en      (cnt_en),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  assign expire    = expire_q;
  assign remaining = cnt;

endmodule
